// File: rtl/add_share_arb.sv
// Round-robin arbiter sharing one WIDTH-bit adder among NREQ requesters, with a
// single-entry registered result buffer. Define ADD_SHARE_ARB_CARRY_EN to add rsp_cout.
//
// state   | meaning
// --------+-----------------------------------------------
// S_EMPTY | result buffer empty, rsp_valid=0
// S_FULL  | result buffer holds a sum, rsp_valid=1
module add_share_arb #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_sum,
  output logic [1:0]            rsp_id
`ifdef ADD_SHARE_ARB_CARRY_EN
  ,
  output logic                  rsp_cout
`endif
);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t           r_state;
  logic [1:0]       r_ptr;
  logic [WIDTH-1:0] r_sum;
  logic [1:0]       r_id;

  logic             w_can_accept;
  logic             w_gnt_any;
  logic [1:0]       w_gnt_idx;
  logic             w_fire;
  logic [3:0]       w_valid_ext;
  logic [3:0]       w_ready_ext;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_sum;

  // (base + off) mod NREQ; base < NREQ and off < NREQ, so one subtraction suffices
  function automatic logic [1:0] wrap_idx(input logic [1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return s[1:0];
  endfunction

  assign w_valid_ext  = 4'(req_valid);
  assign w_can_accept = (r_state == S_EMPTY) || rsp_ready;

  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = r_ptr;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_gnt_any && w_valid_ext[wrap_idx(r_ptr, k)]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = wrap_idx(r_ptr, k);
      end
    end
  end

  // rst_n gates the grant so no handshake can complete while reset is held
  assign w_fire      = rst_n && w_can_accept && w_gnt_any;
  assign w_ready_ext = w_fire ? (4'b0001 << w_gnt_idx) : 4'b0000;
  assign req_ready   = w_ready_ext[NREQ-1:0];

  always_comb begin
    w_a = '0;
    w_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt_idx == 2'(i)) begin
        w_a = req_a[i*WIDTH +: WIDTH];
        w_b = req_b[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef ADD_SHARE_ARB_CARRY_EN
  logic w_cout;
  logic r_cout;
  assign {w_cout, w_sum} = {1'b0, w_a} + {1'b0, w_b};
  assign rsp_cout = r_cout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cout <= 1'b0;
    end else if (w_fire) begin
      r_cout <= w_cout;
    end
  end
`else
  assign w_sum = w_a + w_b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_ptr   <= 2'd0;
      r_sum   <= '0;
      r_id    <= 2'd0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_fire) begin
            r_state <= S_FULL;
            r_sum   <= w_sum;
            r_id    <= w_gnt_idx;
            r_ptr   <= wrap_idx(w_gnt_idx, 1);
          end
        end
        S_FULL: begin
          if (w_fire) begin
            r_sum <= w_sum;
            r_id  <= w_gnt_idx;
            r_ptr <= wrap_idx(w_gnt_idx, 1);
          end else if (rsp_ready) begin
            r_state <= S_EMPTY;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  assign rsp_valid = (r_state == S_FULL);
  assign rsp_sum   = r_sum;
  assign rsp_id    = r_id;

endmodule

// File: doc/add_share_arb.md
Name: add_share_arb

Overview:
- Arbitrates one shared WIDTH-bit adder datapath among NREQ requesters (e.g. PC increment, ALU, address generation).
- Each requester presents an operand pair with a valid/ready handshake.
- A round-robin grant selects one requester per cycle. The sum is registered into a single-entry output buffer, tagged with the requester index.
- Sits between the rv32i core's requesters and the adder, so only one adder instance is needed.

Parameters:
- WIDTH, 32, operand/result width in bits.
- NREQ, 2, number of requesters; legal range 2..4.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester grant/accept; one-hot or zero.
- req_a  input  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B; same packing as req_a.
- rsp_valid  output  1  result buffer holds a valid sum.
- rsp_ready  input  1  consumer accepts result.
- rsp_sum  output  WIDTH  registered sum.
- rsp_id  output  2  index of the requester that produced rsp_sum.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values: rsp_valid=0, rsp_sum=0, rsp_id=0, round-robin pointer=0.
- While rst_n=0, req_ready=0 combinationally.
- Buffer state machine:
  - EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
  - can_accept = EMPTY, or (FULL and rsp_ready=1), i.e. a same-cycle drain-and-refill is allowed.
- Arbitration (combinational):
  - When can_accept=1, grant the first i with req_valid[i]=1, searching from the pointer upward and wrapping modulo NREQ.
  - req_ready[i]=1 only for the granted i. All req_ready are 0 when can_accept=0 or no requester is valid.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
  - Once asserted, a requester's req_valid and operands must stay stable until accepted.
- Accept (req_valid[i] & req_ready[i]) at the clock edge:
  - rsp_sum <= (req_a_i + req_b_i) mod 2^WIDTH, carry discarded unless the optional feature is enabled.
  - rsp_id <= i.
  - rsp_valid <= 1.
  - pointer <= (i+1) mod NREQ.
- Latency: 1 cycle from accept to rsp_valid.
- Throughput: 1 result per cycle while rsp_ready=1.
- Drain without refill (FULL, rsp_ready=1, no valid requesters): rsp_valid <= 0; rsp_sum and rsp_id hold their last values.
- Backpressure (FULL, rsp_ready=0): rsp_valid, rsp_sum and rsp_id hold; no grant issued; pointer holds.
- Pointer advances only on an accept, never on an idle cycle.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,...,NREQ-1,0,... and no requester waits more than NREQ-1 accepts.
- Wrap-around: 0xFFFFFFFF + 0x00000001 = 0x00000000, with no error indication.
- Reset mid-operation: any buffered result is dropped (rsp_valid=0 immediately) and the pointer returns to 0. A requester whose handshake is in flight must re-present its operands after reset.
- Unused rsp_id bits (NREQ=2: bit 1) are driven 0.

Optional Feature:
- Macro: ADD_SHARE_ARB_CARRY_EN.
- Defined:
  - Adds output port rsp_cout (1 bit), the registered carry-out of the WIDTH-bit add.
  - rsp_cout is captured and held under exactly the same rules as rsp_sum; reset value 0.
- Undefined:
  - No rsp_cout port; the carry is discarded.
  - Functionally identical otherwise.

Test Plan:
1. Single request: NREQ=2, rsp_ready=1, req0 a=0x00000005 b=0x00000007 valid 1 cycle -> req_ready[0]=1 that cycle; next cycle rsp_valid=1, rsp_sum=0x0000000C, rsp_id=0.
2. Contention round-robin: both valid continuously, rsp_ready=1, req0 (1,1), req1 (2,2) -> grants alternate 0,1,0,1 starting at 0; rsp_sum alternates 0x2/0x4; rsp_id alternates 0/1.
3. Backpressure: buffer FULL with sum 0x10, rsp_ready=0 for 3 cycles, req1 valid -> req_ready all 0; rsp_sum stays 0x10; req1 accepted in the same cycle rsp_ready rises; its result appears the next cycle.
4. Wrap/carry: a=0xFFFFFFFF, b=0x00000001 -> rsp_sum=0x00000000; with ADD_SHARE_ARB_CARRY_EN, rsp_cout=1. For a=0x7FFFFFFF, b=0x00000001 -> rsp_sum=0x80000000, rsp_cout=0.
5. Reset mid-operation: rsp_valid=1 pointing at req1; assert rst_n=0 between clock edges -> rsp_valid=0 immediately, req_ready=0. After release with both requesters valid, first grant goes to req0.
6. NREQ=4 fairness: all 4 valid for 8 accepts, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1,2,3. Then only req2 valid -> granted on the next cycle and pointer moves to 3.
